load_store_unit: RTL and testbench

// - Executes RV32I loads/stores: EA = rs1 + imm, drives a valid/ready data-memory port,

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_align.sv | 57 +++++
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM state and fault-cause encodings for the load/store unit.
// Latency: n/a (declarations and pure helper functions only).
// Backpressure: n/a.
package lsu_pkg;

  // RV32I load/store size/sign field
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_ILLEGAL  = 2'b10,
    CAUSE_TIMEOUT  = 2'b11
  } err_cause_e;

  // Stores only have B/H/W; loads additionally have BU/HU.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
  endfunction

  // Size lives in funct3[1:0] for both signed and unsigned variants.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] ea_lo);
    return (f3[1:0] == 2'b01 && ea_lo[0]) || (f3[1:0] == 2'b10 && ea_lo != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane steering and load byte/half extraction with sign/zero extension.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
// Ports: st_* = store steering (funct3, EA[1:0], rs2) -> wdata/wstrb;
//        ld_* = load extraction (funct3, EA[1:0], read word) -> extended result.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_lane_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_wstrb_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_lane_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_result_o
);

  logic [31:0] shifted;

  always_comb begin
    st_wdata_o = '0;
    st_wstrb_o = '0;
    case (st_funct3_i)
      F3_B: begin
        st_wdata_o = {4{st_data_i[7:0]}};
        st_wstrb_o = 4'b0001 << st_lane_i;
      end
      F3_H: begin
        st_wdata_o = {2{st_data_i[15:0]}};
        st_wstrb_o = 4'b0011 << st_lane_i;
      end
      F3_W: begin
        st_wdata_o = st_data_i;
        st_wstrb_o = 4'hF;
      end
      default: ;
    endcase
  end

  // Bring the addressed byte/half down to bit 0, then extend.
  assign shifted = ld_rdata_i >> {ld_lane_i, 3'b000};

  always_comb begin
    ld_result_o = '0;
    case (ld_funct3_i)
      F3_B:    ld_result_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ld_result_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    ld_result_o = ld_rdata_i;
      F3_BU:   ld_result_o = {24'd0, shifted[7:0]};
      F3_HU:   ld_result_o = {16'd0, shifted[15:0]};
      default: ld_result_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store execution, one request at a time, stalls the core via busy_o.
// Latency: start edge -> mem_valid_o next cycle; done_o/err_o one cycle after accept/fault/timeout.
// Backpressure: request held on mem_valid_o until mem_ready_i; times out after TIMEOUT_CYCLES (0 = never).
// Ports: start_i/is_store_i/funct3_i/base_i/offset_i/store_data_i/rd_i request in;
//        busy_o/done_o/err_o/err_cause_o status; mem_* data-memory port; reg_write_* regfile write port.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] base_i,
  input  logic [31:0] offset_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  rd_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_cause_o,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic [31:0] mem_rdata_i,
  output logic        reg_write_control_o,
  output logic [4:0]  reg_write_select_o,
  output logic [31:0] reg_write_data_o
);

  lsu_state_e  state_q;
  logic [1:0]  ea_lo_q;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic [31:0] result_q;
  logic [31:0] cnt_q;
  logic        done_q, err_q, rwc_q;
  err_cause_e  cause_q;
  logic        mem_valid_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_wstrb_q;

  logic [31:0] ea_d;
  logic [31:0] cnt_d;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] ld_result;

  assign ea_d  = base_i + offset_i;  // wraps mod 2^32
  assign cnt_d = cnt_q + 32'd1;

  // Store steering uses the live request so wdata/wstrb can be registered at accept;
  // load extraction uses the latched request against the returning word.
  lsu_align u_align (
    .st_funct3_i (funct3_i),
    .st_lane_i   (ea_d[1:0]),
    .st_data_i   (store_data_i),
    .st_wdata_o  (st_wdata),
    .st_wstrb_o  (st_wstrb),
    .ld_funct3_i (funct3_q),
    .ld_lane_i   (ea_lo_q),
    .ld_rdata_i  (mem_rdata_i),
    .ld_result_o (ld_result)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      ea_lo_q     <= '0;
      is_store_q  <= 1'b0;
      funct3_q    <= '0;
      rd_q        <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rwc_q       <= 1'b0;
      cause_q     <= CAUSE_NONE;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      // Status strobes are single-cycle unless re-asserted below.
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rwc_q   <= 1'b0;
      cause_q <= CAUSE_NONE;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            ea_lo_q    <= ea_d[1:0];
            is_store_q <= is_store_i;
            funct3_q   <= funct3_i;
            rd_q       <= rd_i;
            cnt_q      <= '0;
            if (f3_illegal(is_store_i, funct3_i)) begin
              state_q <= ST_FAULT;
              err_q   <= 1'b1;
              cause_q <= CAUSE_ILLEGAL;
            end else if (misaligned(funct3_i, ea_d[1:0])) begin
              state_q <= ST_FAULT;
              err_q   <= 1'b1;
              cause_q <= CAUSE_MISALIGN;
            end else begin
              state_q     <= ST_REQ;
              mem_valid_q <= 1'b1;
              mem_we_q    <= is_store_i;
              mem_addr_q  <= {ea_d[31:2], 2'b00};
              mem_wdata_q <= is_store_i ? st_wdata : 32'd0;
              mem_wstrb_q <= is_store_i ? st_wstrb : 4'd0;
            end
          end
        end
        ST_REQ: begin
          if (mem_ready_i) begin
            state_q     <= ST_DONE;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= '0;
            result_q    <= ld_result;
            done_q      <= 1'b1;
            rwc_q       <= !is_store_q;
          end else if (TIMEOUT_CYCLES != 0 && cnt_d == TIMEOUT_CYCLES) begin
            state_q     <= ST_FAULT;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b1;
            cause_q     <= CAUSE_TIMEOUT;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_DONE:  state_q <= ST_IDLE;
        ST_FAULT: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o              = (state_q != ST_IDLE);
  assign done_o              = done_q;
  assign err_o               = err_q;
  assign err_cause_o         = cause_q;
  assign mem_valid_o         = mem_valid_q;
  assign mem_we_o            = mem_we_q;
  assign mem_addr_o          = mem_addr_q;
  assign mem_wdata_o         = mem_wdata_q;
  assign mem_wstrb_o         = mem_wstrb_q;
  assign reg_write_control_o = rwc_q;
  assign reg_write_select_o  = rd_q;
  assign reg_write_data_o    = result_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit with a wait-state memory responder.
// Latency: expectations pushed at start, popped on done/err pulses.
// Backpressure: memory ready delayed per transaction; held low to force timeouts.
module tb_load_store_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, is_store, mem_ready;
  logic [2:0]  funct3;
  logic [31:0] base, offset, store_data, mem_rdata;
  logic [4:0]  rd;
  logic        busy, done, err, mem_valid, mem_we, rwc;
  logic [1:0]  err_cause;
  logic [31:0] mem_addr, mem_wdata, rwd;
  logic [3:0]  mem_wstrb;
  logic [4:0]  rws;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .is_store_i(is_store),
    .funct3_i(funct3), .base_i(base), .offset_i(offset), .store_data_i(store_data),
    .rd_i(rd), .busy_o(busy), .done_o(done), .err_o(err), .err_cause_o(err_cause),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
    .mem_rdata_i(mem_rdata), .reg_write_control_o(rwc), .reg_write_select_o(rws),
    .reg_write_data_o(rwd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        err;
    logic [1:0]  cause;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [4:0]  rd;
    logic [31:0] res;
    int          vcnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;
  int   n_exp_done = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic st, input logic [2:0] f3, input logic [31:0] b,
                                 input logic [31:0] o, input logic [31:0] sd, input logic [4:0] r,
                                 input logic [31:0] rdata, input int waits);
    exp_t e;
    logic [31:0] ea;
    logic [1:0]  ln;
    logic [7:0]  by;
    logic [15:0] hw;
    logic        legal, mis;
    ea = b + o;
    ln = ea[1:0];
    by = rdata[8*ln +: 8];
    hw = ln[1] ? rdata[31:16] : rdata[15:0];
    legal = st ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    mis = (f3[1:0] == 2'd1 && ea[0]) || (f3[1:0] == 2'd2 && ln != 2'd0);
    e.st = st; e.rd = r; e.addr = {ea[31:2], 2'b00};
    e.err = 1'b0; e.cause = 2'b00; e.wdata = 32'd0; e.wstrb = 4'd0; e.res = 32'd0;
    if (st) begin
      case (f3)
        3'd0: begin e.wdata = {4{sd[7:0]}};  e.wstrb = 4'b0001 << ln; end
        3'd1: begin e.wdata = {2{sd[15:0]}}; e.wstrb = 4'b0011 << ln; end
        3'd2: begin e.wdata = sd;            e.wstrb = 4'hF; end
        default: ;
      endcase
    end else begin
      case (f3)
        3'd0: e.res = {{24{by[7]}}, by};
        3'd1: e.res = {{16{hw[15]}}, hw};
        3'd2: e.res = rdata;
        3'd4: e.res = {24'd0, by};
        3'd5: e.res = {16'd0, hw};
        default: ;
      endcase
    end
    if (!legal) begin e.err = 1'b1; e.cause = 2'b10; e.vcnt = 0; end
    else if (mis) begin e.err = 1'b1; e.cause = 2'b01; e.vcnt = 0; end
    else if (waits < 0) begin e.err = 1'b1; e.cause = 2'b11; e.vcnt = TO; end
    else e.vcnt = waits + 1;
    return e;
  endfunction

  // Monitor: checks the held request every valid cycle and retires entries on done/err.
  int   vcnt = 0;
  logic chk_busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      vcnt = 0;
      chk_busy = 1'b0;
    end else begin
      if (chk_busy) begin
        check("busy_after_end", busy, 0);
        chk_busy = 1'b0;
      end
      if (mem_valid) begin
        vcnt++;
        check("req_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb[0];
          check("mem_addr", mem_addr, e.addr);
          check("mem_we", mem_we, e.st);
          check("mem_wstrb", mem_wstrb, e.wstrb);
          if (e.st) check("mem_wdata", mem_wdata, e.wdata);
        end
      end
      if (rwc) check("rwc_only_with_done", done, 1);
      if (done || err) begin
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("done", done, !e.err);
          check("err", err, e.err);
          if (e.err) check("err_cause", err_cause, e.cause);
          check("reg_write_control", rwc, !e.err && !e.st);
          if (rwc) begin
            check("reg_write_select", rws, e.rd);
            check("reg_write_data", rwd, e.res);
          end
          check("valid_cycles", vcnt, e.vcnt);
        end
        if (done) n_done++;
        vcnt = 0;
        chk_busy = 1'b1;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) check("busy_drop_bound", busy, 0);
  endtask

  // waits < 0: memory never answers. poke: pulse an unrelated start while in REQ.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] b,
                        input logic [31:0] o, input logic [31:0] sd, input logic [4:0] r,
                        input logic [31:0] rdata, input int waits, input logic poke);
    exp_t e;
    e = model(st, f3, b, o, sd, r, rdata, waits);
    sb.push_back(e);
    if (!e.err) n_exp_done++;
    is_store = st; funct3 = f3; base = b; offset = o; store_data = sd; rd = r;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (e.vcnt != 0 && waits >= 0) begin
      for (int i = 0; i < waits; i++) begin
        if (poke && i == 0) begin
          start = 1'b1; is_store = ~st; funct3 = 3'd2; base = 32'h0000_0F00;
          offset = 32'd0; store_data = 32'h5555_5555; rd = 5'd31;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
      end
      start = 1'b0;
      mem_rdata = rdata;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; mem_ready = 1'b0; funct3 = '0;
    base = '0; offset = '0; store_data = '0; mem_rdata = '0; rd = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_err_cause", err_cause, 0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    check("rst_rwc", rwc, 0);
    check("rst_rwd", rwd, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op(0, 3'b010, 32'h100, 32'd4, 32'h0, 5'd5, 32'hDEADBEEF, 2, 0);  // LW
    check("lw_result_const", rwd, 32'hDEADBEEF);
    run_op(0, 3'b000, 32'h200, 32'd3, 32'h0, 5'd6, 32'h80112233, 0, 0);  // LB
    check("lb_result_const", rwd, 32'hFFFFFF80);
    run_op(0, 3'b100, 32'h200, 32'd3, 32'h0, 5'd7, 32'h80112233, 1, 0);  // LBU
    run_op(0, 3'b101, 32'h200, 32'd2, 32'h0, 5'd8, 32'h80112233, 0, 0);  // LHU
    check("lhu_result_const", rwd, 32'h00008011);
    run_op(1, 3'b001, 32'h200, 32'd2, 32'h1234ABCD, 5'd9, 32'h0, 1, 0);  // SH
    run_op(0, 3'b010, 32'h100, 32'd1, 32'h0, 5'd1, 32'h0, 0, 0);         // misaligned LW
    run_op(0, 3'b011, 32'h100, 32'd0, 32'h0, 5'd1, 32'h0, 0, 0);         // illegal load
    run_op(1, 3'b100, 32'h100, 32'd0, 32'h0, 5'd1, 32'h0, 0, 0);         // illegal store
    run_op(1, 3'b001, 32'h100, 32'd1, 32'h0, 5'd1, 32'h0, 0, 0);         // misaligned SH
    run_op(0, 3'b010, 32'h400, 32'd0, 32'h0, 5'd2, 32'h0, -1, 0);        // timeout
    run_op(0, 3'b001, 32'h300, 32'd0, 32'h0, 5'd3, 32'h7FFF8001, 0, 0);  // LH
    run_op(1, 3'b000, 32'h0, 32'd3, 32'h000000A5, 5'd4, 32'h0, 0, 0);    // SB lane 3
    run_op(1, 3'b010, 32'h10, 32'd0, 32'hCAFEF00D, 5'd4, 32'h0, 3, 0);   // SW
    run_op(0, 3'b010, 32'hFFFFFFFC, 32'd8, 32'h0, 5'd10, 32'h01020304, 0, 0);  // EA wraps
    run_op(0, 3'b010, 32'h500, 32'd0, 32'h0, 5'd0, 32'h11111111, 0, 0);  // rd=0 still writes
    run_op(0, 3'b010, 32'h600, 32'd0, 32'h0, 5'd11, 32'h22222222, 3, 1); // start during REQ
    repeat (3) @(posedge clk);
    #1;
    check("no_extra_txn", busy, 0);

    // Back-to-back random traffic
    for (int i = 0; i < 24; i++) begin
      run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFF0,
             32'($urandom_range(0, 15)), $urandom, 5'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 3), 0);
    end

    // Reset in the middle of a request abandons it immediately.
    e = model(0, 3'b010, 32'h700, 32'd0, 32'h0, 5'd12, 32'h0, 5);
    sb.push_back(e);
    is_store = 1'b0; funct3 = 3'b010; base = 32'h700; offset = 32'd0; rd = 5'd12;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("mid_req_valid", mem_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", mem_valid, 0);
    check("rst_mid_busy", busy, 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(0, 3'b010, 32'h800, 32'd0, 32'h0, 5'd13, 32'h33333333, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    check("done_count", n_done, n_exp_done);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
